// File: rtl/fb_ctrl.sv
// Single-bit pixel port and scan-out byte port sharing one byte-wide synchronous RAM.
// Pixel writes are read-modify-write; every output is registered.
module fb_ctrl #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 200,
  parameter int unsigned ABITS  = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [8:0]       x_b,
  input  logic [7:0]       y_b,
  input  logic             read_b,
  input  logic             write_b,
  input  logic             in_b,
  output logic             out_b,
  output logic             rdy_b,
  input  logic             scan_req,
  input  logic [ABITS-1:0] scan_addr,
  output logic [7:0]       scan_data,
  output logic             scan_ack,
  output logic [ABITS-1:0] mem_addr,
  output logic             mem_we,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata
);

  typedef enum logic [2:0] {
    StIdle, StPxWait, StPxData, StPxWb, StScWait, StScData
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       bit_q, bit_d;
  logic             in_q, in_d;
  logic             wr_q, wr_d;
  logic             oor_q, oor_d;
  logic             out_q, out_d;
  logic             rdy_q, rdy_d;
  logic             ack_q, ack_d;
  logic             we_q, we_d;
  logic [7:0]       sdata_q, sdata_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [ABITS-1:0] addr_q, addr_d;

  logic [ABITS-1:0] px_addr;
  logic             px_oor;

  // y*40 as two shifts; 40 bytes per 320-pixel row.
  assign px_addr = ABITS'({y_b, 5'b0}) + ABITS'({y_b, 3'b0}) + ABITS'(x_b[8:3]);
  assign px_oor  = (32'(x_b) >= WIDTH) || (32'(y_b) >= HEIGHT);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    in_d    = in_q;
    wr_d    = wr_q;
    oor_d   = oor_q;
    out_d   = out_q;
    rdy_d   = rdy_q;
    ack_d   = 1'b0;
    we_d    = 1'b0;
    sdata_d = sdata_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    case (state_q)
      StIdle: begin
        if (write_b || read_b) begin
          // Write wins when both strobes arrive together.
          bit_d   = x_b[2:0];
          in_d    = in_b;
          wr_d    = write_b;
          oor_d   = px_oor;
          addr_d  = px_addr;
          rdy_d   = 1'b0;
          state_d = StPxWait;
        end else if (scan_req) begin
          addr_d  = scan_addr;
          rdy_d   = 1'b0;
          state_d = StScWait;
        end
      end
      StPxWait: state_d = StPxData;
      StPxData: begin
        if (wr_q) begin
          if (!oor_q) begin
            wdata_d         = mem_rdata;
            wdata_d[bit_q]  = in_q;
            we_d            = 1'b1;
          end
          state_d = StPxWb;
        end else begin
          out_d   = oor_q ? 1'b0 : mem_rdata[bit_q];
          rdy_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StPxWb: begin
        rdy_d   = 1'b1;
        state_d = StIdle;
      end
      StScWait: state_d = StScData;
      StScData: begin
        sdata_d = mem_rdata;
        ack_d   = 1'b1;
        rdy_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      bit_q   <= '0;
      in_q    <= 1'b0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      out_q   <= 1'b0;
      rdy_q   <= 1'b1;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      sdata_q <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      in_q    <= in_d;
      wr_q    <= wr_d;
      oor_q   <= oor_d;
      out_q   <= out_d;
      rdy_q   <= rdy_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      sdata_q <= sdata_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
    end
  end

  assign out_b     = out_q;
  assign rdy_b     = rdy_q;
  assign scan_ack  = ack_q;
  assign scan_data = sdata_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign mem_addr  = addr_q;

endmodule

// File: doc/fb_ctrl.md
FB_CTRL -- requirements
Module: fb_ctrl

Interface
REQ-001 The block SHALL expose the following parameters: WIDTH 320, horizontal pixel count; HEIGHT 200, vertical pixel count; ABITS 13, memory byte-address width.
REQ-002 The block SHALL expose the following ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- x_b  in  9  pixel column from the GPU command block.
- y_b  in  8  pixel row.
- read_b  in  1  single-cycle pixel read strobe.
- write_b  in  1  single-cycle pixel write strobe.
- in_b  in  1  pixel value to write.
- out_b  out  1  pixel value read.
- rdy_b  out  1  high = idle, able to accept a strobe.
- scan_req  in  1  level; scan-out byte read request.
- scan_addr  in  13  scan-out byte address.
- scan_data  out  8  scan-out byte result.
- scan_ack  out  1  one-cycle pulse; scan_data valid.
- mem_addr  out  13  byte-wide synchronous RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data, valid one cycle after mem_addr is registered.

Function
REQ-003 Pixel mapping SHALL be: byte address = y_b*40 + x_b[8:3], computed as (y_b<<5)+(y_b<<3)+x_b[8:3] in 13 bits; bit index = x_b[2:0], with bit 0 as the leftmost pixel of the byte.
REQ-004 States SHALL be IDLE, PX_WAIT, PX_DATA, PX_WB, SC_WAIT and SC_DATA; all outputs are registered.
REQ-005 rdy_b SHALL be high only in IDLE and SHALL drop on the same edge that samples a strobe, so the initiator sees rdy_b=0 on the cycle after its strobe.
REQ-006 In IDLE, a sampled read_b or write_b SHALL latch the coordinates, in_b, the operation type, and an out-of-range flag (x_b>=320 or y_b>=200); register mem_addr; and go to PX_WAIT.
REQ-007 If read_b and write_b are sampled together, the write SHALL take effect and the read SHALL be ignored.
REQ-008 Pixel strobes SHALL have priority over scan_req in the same IDLE cycle; scan_req stays pending.
REQ-009 Transitions SHALL be: PX_WAIT -> PX_DATA unconditionally, at which point mem_rdata is valid.
REQ-010 Read in PX_DATA: out_b <= mem_rdata[bit]; out_b <= 0 if out of range; rdy_b <= 1; return to IDLE. rdy_b is low for 2 cycles.
REQ-011 Write in PX_DATA: mem_wdata <= mem_rdata with bit [bit] replaced by the latched in_b; mem_we <= 1; go to PX_WB.
REQ-012 Write in PX_WB: mem_we <= 0, rdy_b <= 1, return to IDLE. rdy_b is low for 3 cycles and mem_we is high for exactly 1 cycle.
REQ-013 An out-of-range write SHALL never assert mem_we but SHALL follow the same state sequence and timing.
REQ-014 out_b SHALL hold its value until the next completed read.
REQ-015 Scan path: in IDLE, with scan_req high and no strobe, the block SHALL register mem_addr <= scan_addr and go to SC_WAIT, then SC_DATA.
REQ-016 In SC_DATA the block SHALL register scan_data <= mem_rdata, pulse scan_ack for 1 cycle, and return to IDLE.
REQ-017 The requester drops scan_req on the edge that samples scan_ack; a still-high scan_req in the following IDLE cycle SHALL start a new read.
REQ-018 Strobes arriving outside IDLE SHALL be ignored; the initiator obeys rdy_b.
REQ-019 scan_addr >= 8000 SHALL be passed to the RAM unchecked.

Reset
REQ-020 While rst is high: state=IDLE, rdy_b=1, out_b=0, scan_ack=0, scan_data=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-021 Reset mid-operation SHALL abandon the operation with no further RAM write; mem_we deasserts asynchronously.
REQ-022 RAM contents are not cleared by reset.

Verification
REQ-023 Write (x=13,y=2,in=1) into a zeroed RAM -> mem_addr=81, mem_wdata=8'h20, one mem_we pulse, rdy_b low 3 cycles; then read (13,2) -> out_b=1 after 2 low cycles.
REQ-024 Eight writes x=0..7, y=0, data 1,0,1,1,0,0,0,1 (GPU byte-write pattern) -> RAM[0]=8'h8D; scan_req with scan_addr=0 -> scan_data=8'h8D with a single scan_ack.
REQ-025 Write (x=319,y=199,in=1) -> byte 7999 bit 7 set; write (x=320,y=0) and (x=0,y=200) -> no mem_we; read (x=400,y=0) -> out_b=0.
REQ-026 write_b and scan_req rise in the same IDLE cycle -> the pixel write completes first, then the scan is served; scan_ack occurs exactly once.
REQ-027 rst pulsed during PX_DATA of a write -> no mem_we ever, rdy_b=1 immediately, RAM byte unchanged, and the next strobe is served normally.
